// File: rtl/frv_rvfi_tracer.sv
// ---------------------------------------------------------------------------
// frv_rvfi_tracer
//
// Producer end of the RVFI trace interface. Dispatch records from the
// decode/execute boundary are queued in a small FIFO. Writeback retirement
// events are matched with them strictly in order. One registered rvfi_*
// record is emitted for each retired instruction. This block is used only in
// formal and simulation builds.
//
// Ports
//   g_clk, g_reset        core clock, synchronous active-high reset
//   d_valid / d_ready     dispatch record handshake
//   d_pc, d_insn          dispatched instruction PC and instruction word
//   d_rs_addr, d_rs_rdata {rs3,rs2,rs1} source addresses and operand values
//   flush                 discard every record that has not yet retired
//   w_valid               retirement of the oldest dispatched instruction
//   w_trap, w_rd_*, w_pc_wdata, w_mem_*
//                         retirement-side fields of the trace record
//   rvfi_*                merged trace record; rvfi_valid is a 1-cycle pulse
//   trace_err             sticky protocol-error flag (empty retire or a
//                         break in PC continuity)
// ---------------------------------------------------------------------------
module frv_rvfi_tracer #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic                  g_clk,
    input  logic                  g_reset,

    input  logic                  d_valid,
    output logic                  d_ready,
    input  logic [XLEN-1:0]       d_pc,
    input  logic [31:0]           d_insn,
    input  logic [14:0]           d_rs_addr,
    input  logic [3*XLEN-1:0]     d_rs_rdata,

    input  logic                  flush,

    input  logic                  w_valid,
    input  logic                  w_trap,
    input  logic [4:0]            w_rd_addr,
    input  logic [XLEN-1:0]       w_rd_wdata,
    input  logic [XLEN-1:0]       w_pc_wdata,
    input  logic [XLEN-1:0]       w_mem_addr,
    input  logic [2*XLEN/8-1:0]   w_mem_mask,
    input  logic [XLEN-1:0]       w_mem_rdata,
    input  logic [XLEN-1:0]       w_mem_wdata,

    output logic                  rvfi_valid,
    output logic [63:0]           rvfi_order,
    output logic [31:0]           rvfi_insn,
    output logic [XLEN-1:0]       rvfi_pc_rdata,
    output logic [14:0]           rvfi_rs_addr,
    output logic [3*XLEN-1:0]     rvfi_rs_rdata,
    output logic                  rvfi_trap,
    output logic [4:0]            rvfi_rd_addr,
    output logic [XLEN-1:0]       rvfi_rd_wdata,
    output logic [XLEN-1:0]       rvfi_pc_wdata,
    output logic [XLEN-1:0]       rvfi_mem_addr,
    output logic [2*XLEN/8-1:0]   rvfi_mem_mask,
    output logic [XLEN-1:0]       rvfi_mem_rdata,
    output logic [XLEN-1:0]       rvfi_mem_wdata,

    output logic                  trace_err
);

    localparam int AW = $clog2(DEPTH);

    // Dispatch-record storage.
    logic [XLEN-1:0]   pc_mem    [DEPTH];
    logic [31:0]       insn_mem  [DEPTH];
    logic [14:0]       rsa_mem   [DEPTH];
    logic [3*XLEN-1:0] rsd_mem   [DEPTH];

    // The pointers carry one extra wrap bit. Equal pointers mean the FIFO is
    // empty. Pointers whose index bits match but whose wrap bits differ mean
    // the FIFO is full.
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic [AW-1:0]     head;

    // PC continuity tracking across non-trap emissions.
    logic [XLEN-1:0]   prev_pc_wdata;
    logic              prev_ok;
    logic              cont_err;

    logic [63:0]       order_cnt;

    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty = (wr_ptr == rd_ptr);
    assign head  = rd_ptr[AW-1:0];

    // There is no bypass in either direction. A retire in the same cycle
    // does not make room for a push, and a push in the same cycle does not
    // feed an otherwise empty retire.
    assign d_ready = !full;
    assign push    = d_valid && !full && !flush;
    assign pop     = w_valid && !empty;

    assign cont_err = pop && !w_trap && prev_ok && (pc_mem[head] != prev_pc_wdata);

    // NOTE: storage has no reset. The pointers fully qualify every read, so
    // stale contents are never observed, and leaving the array unreset keeps
    // it mappable to plain RAM.
    always_ff @(posedge g_clk) begin
        if (push) begin
            pc_mem[wr_ptr[AW-1:0]]   <= d_pc;
            insn_mem[wr_ptr[AW-1:0]] <= d_insn;
            rsa_mem[wr_ptr[AW-1:0]]  <= d_rs_addr;
            rsd_mem[wr_ptr[AW-1:0]]  <= d_rs_rdata;
        end
    end

    // NOTE: all state uses non-blocking assignments, so every read in this
    // edge sees the values from before the edge.
    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            // The head may still retire in this cycle; its output is built
            // from the pre-flush head index, so collapsing both pointers is safe.
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Continuity reference. Trap emissions neither check against it nor
    // update it. A flush re-arms the "first emission" skip after any
    // emission that happens in the same cycle.
    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            prev_pc_wdata <= '0;
            prev_ok       <= 1'b0;
        end else begin
            if (pop && !w_trap) begin
                prev_pc_wdata <= w_pc_wdata;
                prev_ok       <= 1'b1;
            end
            if (flush) prev_ok <= 1'b0;
        end
    end

    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            trace_err <= 1'b0;
        end else if ((w_valid && empty) || cont_err) begin
            trace_err <= 1'b1;
        end
    end

    // Registered trace record. The fields hold their values between
    // emissions; only rvfi_valid drops back to 0.
    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            order_cnt      <= '0;
            rvfi_valid     <= 1'b0;
            rvfi_order     <= '0;
            rvfi_insn      <= '0;
            rvfi_pc_rdata  <= '0;
            rvfi_rs_addr   <= '0;
            rvfi_rs_rdata  <= '0;
            rvfi_trap      <= 1'b0;
            rvfi_rd_addr   <= '0;
            rvfi_rd_wdata  <= '0;
            rvfi_pc_wdata  <= '0;
            rvfi_mem_addr  <= '0;
            rvfi_mem_mask  <= '0;
            rvfi_mem_rdata <= '0;
            rvfi_mem_wdata <= '0;
        end else begin
            rvfi_valid <= pop;
            if (pop) begin
                order_cnt      <= order_cnt + 64'd1;
                rvfi_order     <= order_cnt;
                rvfi_insn      <= insn_mem[head];
                rvfi_pc_rdata  <= pc_mem[head];
                rvfi_rs_addr   <= rsa_mem[head];
                rvfi_rs_rdata  <= rsd_mem[head];
                rvfi_trap      <= w_trap;
                // A trapped instruction writes no register and performs no
                // memory access. A write to x0 is reported with zero data.
                rvfi_rd_addr   <= w_trap ? 5'd0 : w_rd_addr;
                rvfi_rd_wdata  <= (w_trap || (w_rd_addr == 5'd0)) ? '0 : w_rd_wdata;
                rvfi_pc_wdata  <= w_pc_wdata;
                rvfi_mem_addr  <= w_mem_addr;
                rvfi_mem_mask  <= w_trap ? '0 : w_mem_mask;
                rvfi_mem_rdata <= w_mem_rdata;
                rvfi_mem_wdata <= w_mem_wdata;
            end
        end
    end

endmodule

// File: tb/tb_frv_rvfi_tracer.sv
// ---------------------------------------------------------------------------
// Testbench for frv_rvfi_tracer.
// The driver applies one cycle of stimulus at a time: directed scenarios
// first, then random traffic. A reference model holds the outstanding
// dispatch records in a queue. It pushes each expected trace record into a
// scoreboard queue. A separate monitor samples the DUT on the falling edge
// and checks it against the scoreboard.
// ---------------------------------------------------------------------------
module tb_frv_rvfi_tracer;

    localparam int XLEN  = 32;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [31:0] insn;
        logic [31:0] pc_rdata;
        logic [14:0] rs_addr;
        logic [95:0] rs_rdata;
        logic        trap;
        logic [4:0]  rd_addr;
        logic [31:0] rd_wdata;
        logic [31:0] pc_wdata;
        logic [31:0] mem_addr;
        logic [7:0]  mem_mask;
        logic [31:0] mem_rdata;
        logic [31:0] mem_wdata;
        logic [63:0] order;
    } rec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] insn;
        logic [14:0] rs_addr;
        logic [95:0] rs_rdata;
    } disp_t;

    logic        clk = 1'b0;
    logic        g_reset = 1'b1;
    logic        d_valid = 1'b0;
    logic        d_ready;
    logic [31:0] d_pc = '0;
    logic [31:0] d_insn = '0;
    logic [14:0] d_rs_addr = '0;
    logic [95:0] d_rs_rdata = '0;
    logic        flush = 1'b0;
    logic        w_valid = 1'b0;
    logic        w_trap = 1'b0;
    logic [4:0]  w_rd_addr = '0;
    logic [31:0] w_rd_wdata = '0;
    logic [31:0] w_pc_wdata = '0;
    logic [31:0] w_mem_addr = '0;
    logic [7:0]  w_mem_mask = '0;
    logic [31:0] w_mem_rdata = '0;
    logic [31:0] w_mem_wdata = '0;

    logic        rvfi_valid;
    logic [63:0] rvfi_order;
    logic [31:0] rvfi_insn;
    logic [31:0] rvfi_pc_rdata;
    logic [14:0] rvfi_rs_addr;
    logic [95:0] rvfi_rs_rdata;
    logic        rvfi_trap;
    logic [4:0]  rvfi_rd_addr;
    logic [31:0] rvfi_rd_wdata;
    logic [31:0] rvfi_pc_wdata;
    logic [31:0] rvfi_mem_addr;
    logic [7:0]  rvfi_mem_mask;
    logic [31:0] rvfi_mem_rdata;
    logic [31:0] rvfi_mem_wdata;
    logic        trace_err;

    always #5 clk = ~clk;

    frv_rvfi_tracer #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .g_clk          (clk),
        .g_reset        (g_reset),
        .d_valid        (d_valid),
        .d_ready        (d_ready),
        .d_pc           (d_pc),
        .d_insn         (d_insn),
        .d_rs_addr      (d_rs_addr),
        .d_rs_rdata     (d_rs_rdata),
        .flush          (flush),
        .w_valid        (w_valid),
        .w_trap         (w_trap),
        .w_rd_addr      (w_rd_addr),
        .w_rd_wdata     (w_rd_wdata),
        .w_pc_wdata     (w_pc_wdata),
        .w_mem_addr     (w_mem_addr),
        .w_mem_mask     (w_mem_mask),
        .w_mem_rdata    (w_mem_rdata),
        .w_mem_wdata    (w_mem_wdata),
        .rvfi_valid     (rvfi_valid),
        .rvfi_order     (rvfi_order),
        .rvfi_insn      (rvfi_insn),
        .rvfi_pc_rdata  (rvfi_pc_rdata),
        .rvfi_rs_addr   (rvfi_rs_addr),
        .rvfi_rs_rdata  (rvfi_rs_rdata),
        .rvfi_trap      (rvfi_trap),
        .rvfi_rd_addr   (rvfi_rd_addr),
        .rvfi_rd_wdata  (rvfi_rd_wdata),
        .rvfi_pc_wdata  (rvfi_pc_wdata),
        .rvfi_mem_addr  (rvfi_mem_addr),
        .rvfi_mem_mask  (rvfi_mem_mask),
        .rvfi_mem_rdata (rvfi_mem_rdata),
        .rvfi_mem_wdata (rvfi_mem_wdata),
        .trace_err      (trace_err)
    );

    // Reference-model state. It always describes the state after the most
    // recent rising edge.
    disp_t       mq[$];
    rec_t        exp_q[$];
    rec_t        held = '0;
    logic [63:0] m_order = '0;
    logic        m_err = 1'b0;
    logic        m_prev_ok = 1'b0;
    logic [31:0] m_prev_pcw = '0;
    bit          active = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // One clock cycle of stimulus plus the model update for the next edge.
    task automatic cyc(input bit rst, input bit dv, input bit wv, input bit fl,
                       input bit tr, input logic [4:0] rd, input logic [31:0] rdw,
                       input logic [7:0] mask, input logic [31:0] dpc,
                       input logic [31:0] pcw);
        disp_t d;
        rec_t  r;
        bit    was_full;
        @(negedge clk);
        #1;
        g_reset     = rst;
        d_valid     = dv;
        d_pc        = dpc;
        d_insn      = $urandom;
        d_rs_addr   = 15'($urandom);
        d_rs_rdata  = {$urandom, $urandom, $urandom};
        flush       = fl;
        w_valid     = wv;
        w_trap      = tr;
        w_rd_addr   = rd;
        w_rd_wdata  = rdw;
        w_pc_wdata  = pcw;
        w_mem_addr  = $urandom;
        w_mem_mask  = mask;
        w_mem_rdata = $urandom;
        w_mem_wdata = $urandom;

        if (rst) begin
            mq.delete();
            exp_q.delete();
            held      = '0;
            m_order   = '0;
            m_err     = 1'b0;
            m_prev_ok = 1'b0;
        end else begin
            was_full = (mq.size() == DEPTH);
            if (wv) begin
                if (mq.size() == 0) begin
                    m_err = 1'b1;
                end else begin
                    d = mq.pop_front();
                    r.insn      = d.insn;
                    r.pc_rdata  = d.pc;
                    r.rs_addr   = d.rs_addr;
                    r.rs_rdata  = d.rs_rdata;
                    r.trap      = tr;
                    r.rd_addr   = tr ? 5'd0 : rd;
                    r.rd_wdata  = (tr || rd == 5'd0) ? 32'd0 : rdw;
                    r.pc_wdata  = pcw;
                    r.mem_addr  = w_mem_addr;
                    r.mem_mask  = tr ? 8'd0 : mask;
                    r.mem_rdata = w_mem_rdata;
                    r.mem_wdata = w_mem_wdata;
                    r.order     = m_order;
                    m_order     = m_order + 64'd1;
                    if (!tr) begin
                        if (m_prev_ok && d.pc != m_prev_pcw) m_err = 1'b1;
                        m_prev_pcw = pcw;
                        m_prev_ok  = 1'b1;
                    end
                    exp_q.push_back(r);
                end
            end
            if (fl) begin
                mq.delete();
                m_prev_ok = 1'b0;
            end else if (dv && !was_full) begin
                d.pc       = dpc;
                d.insn     = d_insn;
                d.rs_addr  = d_rs_addr;
                d.rs_rdata = d_rs_rdata;
                mq.push_back(d);
            end
        end
    endtask

    // Monitor: samples on the falling edge, half a cycle after the outputs
    // were registered.
    initial begin
        rec_t a;
        rec_t e;
        forever begin
            @(negedge clk);
            if (active) begin
                a.insn      = rvfi_insn;
                a.pc_rdata  = rvfi_pc_rdata;
                a.rs_addr   = rvfi_rs_addr;
                a.rs_rdata  = rvfi_rs_rdata;
                a.trap      = rvfi_trap;
                a.rd_addr   = rvfi_rd_addr;
                a.rd_wdata  = rvfi_rd_wdata;
                a.pc_wdata  = rvfi_pc_wdata;
                a.mem_addr  = rvfi_mem_addr;
                a.mem_mask  = rvfi_mem_mask;
                a.mem_rdata = rvfi_mem_rdata;
                a.mem_wdata = rvfi_mem_wdata;
                a.order     = rvfi_order;
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("rvfi_valid_pulse", rvfi_valid, 1'b1);
                    check("record", a, e);
                    held = e;
                end else begin
                    check("rvfi_valid_idle", rvfi_valid, 1'b0);
                    check("held_fields", a, held);
                end
                check("trace_err", trace_err, m_err);
                check("d_ready", d_ready, mq.size() < DEPTH);
            end
        end
    end

    initial begin
        logic [31:0] next_pc;
        bit          rst, dv, wv, fl, tr, acc;
        logic [4:0]  rd;
        logic [31:0] pcw;

        // Reset.
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        active = 1'b1;
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Three records, retired on consecutive cycles.
        cyc(0, 1, 0, 0, 0, 0, 0, 0, 32'h100, 0);
        cyc(0, 1, 0, 0, 0, 0, 0, 0, 32'h104, 0);
        cyc(0, 1, 0, 0, 0, 0, 0, 0, 32'h108, 0);
        cyc(0, 0, 1, 0, 0, 5'd1, 32'h11, 8'h0F, 0, 32'h104);
        cyc(0, 0, 1, 0, 0, 5'd2, 32'h22, 8'hF0, 0, 32'h108);
        cyc(0, 0, 1, 0, 0, 5'd3, 32'h33, 8'h00, 0, 32'h10C);

        // Fill to full, then retire and push together: the push is refused.
        cyc(0, 1, 0, 0, 0, 0, 0, 0, 32'h10C, 0);
        cyc(0, 1, 0, 0, 0, 0, 0, 0, 32'h110, 0);
        cyc(0, 1, 0, 0, 0, 0, 0, 0, 32'h114, 0);
        cyc(0, 1, 0, 0, 0, 0, 0, 0, 32'h118, 0);
        cyc(0, 1, 1, 0, 0, 5'd4, 32'h44, 8'h01, 32'h999, 32'h110);
        cyc(0, 1, 0, 0, 0, 0, 0, 0, 32'h11C, 0);
        for (int i = 0; i < 4; i++)
            cyc(0, 0, 1, 0, 0, 5'd6, 32'h66, 8'h03, 0, 32'h114 + 32'(4 * i));

        // Empty retire with a simultaneous push.
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 1, 0, 0, 5'd7, 32'h77, 8'h0F, 32'h300, 32'h304);
        cyc(0, 0, 1, 0, 0, 5'd7, 32'h77, 8'h0F, 0, 32'h304);
        // Write to x0, then a trapped retire.
        cyc(0, 1, 0, 0, 0, 0, 0, 0, 32'h304, 0);
        cyc(0, 0, 1, 0, 0, 5'd0, 32'hDEADBEEF, 8'h0F, 0, 32'h308);
        cyc(0, 1, 0, 0, 0, 0, 0, 0, 32'h308, 0);
        cyc(0, 0, 1, 0, 1, 5'd5, 32'h55, 8'h0F, 0, 32'h80);

        // Flush together with a retire, then retire into an empty FIFO.
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0, 0, 0, 32'h400, 0);
        cyc(0, 1, 0, 0, 0, 0, 0, 0, 32'h404, 0);
        cyc(0, 1, 1, 1, 0, 5'd8, 32'h88, 8'h0F, 32'h408, 32'h404);
        cyc(0, 0, 1, 0, 0, 5'd8, 32'h88, 8'h0F, 0, 32'h408);

        // Reset while an emission is visible and the FIFO is half full.
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0, 0, 0, 32'h500, 0);
        cyc(0, 1, 0, 0, 0, 0, 0, 0, 32'h504, 0);
        cyc(0, 1, 1, 0, 0, 5'd9, 32'h99, 8'h0F, 32'h508, 32'h504);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0, 0, 0, 32'h600, 0);
        cyc(0, 0, 1, 0, 0, 5'd10, 32'hAA, 8'h0F, 0, 32'h604);

        // Random traffic. The PCs are mostly continuous, with occasional breaks.
        next_pc = 32'h1000;
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(199) == 0);
            dv  = ($urandom_range(99) < 60);
            wv  = ($urandom_range(99) < 50);
            fl  = ($urandom_range(49) == 0);
            tr  = ($urandom_range(99) < 20);
            rd  = ($urandom_range(9) < 2) ? 5'd0 : 5'($urandom);
            pcw = (mq.size() > 0 && $urandom_range(19) != 0) ? mq[0].pc + 32'd4 : $urandom;
            acc = !rst && !fl && dv && (mq.size() < DEPTH);
            cyc(rst, dv, wv, fl, tr, rd, $urandom, 8'($urandom), next_pc, pcw);
            if (acc) next_pc = next_pc + 32'd4;
        end

        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        #1;
        check("scoreboard_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
